// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared types and default sizing for the edge request arbiter.
// Holds the arbiter FSM state enum and the default N / TIMEOUT values.
package edge_arb_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pe_pulse.sv
// pe_pulse: two-flop synchronizer plus rising-edge detector for one async line.
// Ports: clk, reset (async, active-high), i_async in, o_pulse one-cycle event.
module pe_pulse (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_pulse
);

  logic       r_s0;
  logic       r_s1;
  logic       r_prev;
  logic       r_arm;
  logic [1:0] r_rdy;

  // r_rdy marks when r_s1 holds a real sample after reset.
  // r_arm only sets once that sample is low, so a line that
  // was already high at reset release cannot fire an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s0   <= 1'b0;
      r_s1   <= 1'b0;
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
      r_rdy  <= 2'b00;
    end else begin
      r_s0   <= i_async;
      r_s1   <= r_s0;
      r_prev <= r_s1;
      r_rdy  <= {r_rdy[0], 1'b1};
      if (r_rdy[1] && !r_s1)
        r_arm <= 1'b1;
    end
  end

  assign o_pulse = r_s1 & ~r_prev & r_arm;

endmodule

// File: rtl/edge_req_arbiter.sv
// edge_req_arbiter: round-robin arbiter for edge-triggered requests with timeout.
// Ports: clk, reset, req[N], done, clear_overrun -> grant[N], busy, pending[N], overrun[N], timeout.
module edge_req_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         done,
  input  logic         clear_overrun,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic [N-1:0] pending,
  output logic [N-1:0] overrun,
  output logic         timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(N - 1);

  arb_state_e    r_state;
  logic [N-1:0]  r_grant;
  logic          r_busy;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_overrun;
  logic          r_timeout;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_gidx;
  logic [TW-1:0] r_timer;

  logic [N-1:0]  w_ev;
  logic [N-1:0]  w_sel_oh;
  logic [PW-1:0] w_sel_idx;
  logic          w_sel_vld;
  logic          w_enter;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_ovr_set;
  logic [N-1:0]  w_pend_nxt;
  logic [N-1:0]  w_ovr_nxt;
  logic [PW-1:0] w_nxt_ptr;

  for (genvar g = 0; g < N; g++) begin : g_sync
    pe_pulse u_pe (
      .clk     (clk),
      .reset   (reset),
      .i_async (req[g]),
      .o_pulse (w_ev[g])
    );
  end

  // First pending channel at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j         = 0;
    w_sel_oh  = '0;
    w_sel_idx = '0;
    w_sel_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= N)
        j = j - N;
      if (!w_sel_vld && r_pending[j]) begin
        w_sel_vld   = 1'b1;
        w_sel_idx   = PW'(j);
        w_sel_oh[j] = 1'b1;
      end
    end
  end

  assign w_enter = (r_state == IDLE) && w_sel_vld;
  assign w_clr   = w_enter ? w_sel_oh : '0;

  // A new event on a channel that stays pending is an overrun.
  // An event on the bit being granted just re-arms it.
  assign w_ovr_set  = w_ev & r_pending & ~w_clr;
  assign w_pend_nxt = (r_pending & ~w_clr) | w_ev;
  assign w_ovr_nxt  = (clear_overrun ? '0 : r_overrun)
                    | w_ovr_set;

  assign w_nxt_ptr = (r_gidx == P_LAST) ? '0
                   : r_gidx + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_pending <= '0;
      r_overrun <= '0;
      r_timeout <= 1'b0;
      r_rr_ptr  <= '0;
      r_gidx    <= '0;
      r_timer   <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_overrun <= w_ovr_nxt;
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_sel_vld) begin
            r_state <= GRANT;
            r_grant <= w_sel_oh;
            r_busy  <= 1'b1;
            r_gidx  <= w_sel_idx;
            r_timer <= '0;
          end
        end
        GRANT: begin
          // done wins over a coincident expiry
          if (done) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_nxt_ptr;
          end else if (r_timer == T_LAST) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_rr_ptr  <= w_nxt_ptr;
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign busy    = r_busy;
  assign pending = r_pending;
  assign overrun = r_overrun;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_edge_req_arbiter.sv
// tb_edge_req_arbiter: directed self-checking bench for edge_req_arbiter.
// Drives N=4, TIMEOUT=8 with hand-timed request edges and done pulses.
module tb_edge_req_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic       clear_overrun;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic       timeout;

  int n_tests;
  int n_fail;

  edge_req_arbiter #(.N(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .done          (done),
    .clear_overrun (clear_overrun),
    .grant         (grant),
    .busy          (busy),
    .pending       (pending),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    req = 4'b0000;
    done = 1'b0;
    clear_overrun = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b0000;
    done = 1'b0;
    clear_overrun = 1'b0;
    repeat (2) tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rst_pending: got %b want 0000", pending); end
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL rst_overrun: got %b want 0000", overrun); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    reset = 1'b0;
    repeat (4) tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_idle_grant: got %b want 0000", grant); end
  endtask

  task automatic test_two_same();
    req = 4'b1001;
    repeat (3) tick();
    n_tests++; if (pending !== 4'b1001) begin n_fail++; $display("FAIL two_pend: got %b want 1001", pending); end
    tick();
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL two_g0: got %b want 0001", grant); end
    n_tests++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL two_pend2: got %b want 1000", pending); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL two_busy: got %b want 1", busy); end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL two_gap: got %b want 0000", grant); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_gap_busy: got %b want 0", busy); end
    tick();
    n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL two_g3: got %b want 1000", grant); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL two_pend3: got %b want 0000", pending); end
    done = 1'b1;
    tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL two_end: got %b want 0000", grant); end
    flush();
  endtask

  task automatic test_single();
    req = 4'b0100;
    repeat (2) tick();
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_pend_e2: got %b want 0000", pending); end
    tick();
    n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL single_pend_e3: got %b want 0100", pending); end
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_e3: got %b want 0000", grant); end
    tick();
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant_e4: got %b want 0100", grant); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_pend_e4: got %b want 0000", pending); end
    repeat (2) tick();
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_hold: got %b want 0100", grant); end
    done = 1'b1;
    tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_done: got %b want 0000", grant); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL single_tmo: got %b want 0", timeout); end
    flush();
  endtask

  // rr_ptr is 3 here, so channel 3 must win over channel 1
  task automatic test_rr_wrap();
    req = 4'b1010;
    repeat (4) tick();
    n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b want 1000", grant); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL wrap_second: got %b want 0010", grant); end
    done = 1'b1;
    tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL wrap_end: got %b want 0000", grant); end
    flush();
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    repeat (4) tick();
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL tmo_grant: got %b want 0010", grant); end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++; if (grant !== 4'b0010 || timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_hold%0d: got g=%b t=%b want g=0010 t=0", i, grant, timeout); end
    end
    tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL tmo_revoke: got %b want 0000", grant); end
    n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b want 1", timeout); end
    tick();
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_end: got %b want 0", timeout); end
    flush();
  endtask

  // rr_ptr is 2 after the timeout on channel 1
  task automatic test_rr_ptr2();
    req = 4'b0110;
    repeat (4) tick();
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL ptr2_first: got %b want 0100", grant); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL ptr2_second: got %b want 0010", grant); end
    done = 1'b1;
    tick();
    flush();
  endtask

  task automatic test_overrun();
    req = 4'b0001;
    repeat (4) tick();
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL ovr_grant0: got %b want 0001", grant); end
    req = 4'b0011;
    repeat (3) tick();
    n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL ovr_pend1: got %b want 0010", pending); end
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_none: got %b want 0000", overrun); end
    req = 4'b0001;
    repeat (2) tick();
    req = 4'b0011;
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_tests++; if (overrun !== 4'b0010) begin n_fail++; $display("FAIL ovr_set: got %b want 0010", overrun); end
    n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL ovr_pend_kept: got %b want 0010", pending); end
    n_tests++; if (grant !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("FAIL ovr_done_at_last: got g=%b t=%b want g=0000 t=0", grant, timeout); end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL ovr_clear: got %b want 0000", overrun); end
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL ovr_grant1: got %b want 0010", grant); end
    done = 1'b1;
    tick();
    flush();
  endtask

  task automatic test_rereq();
    req = 4'b1000;
    repeat (4) tick();
    req = 4'b0000;
    repeat (2) tick();
    req = 4'b1000;
    repeat (3) tick();
    n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rereq_grant: got %b want 1000", grant); end
    n_tests++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL rereq_pend: got %b want 1000", pending); end
    n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL rereq_ovr: got %b want 0000", overrun); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rereq_again: got %b want 1000", grant); end
    done = 1'b1;
    tick();
    flush();
  endtask

  task automatic test_done_expiry();
    req = 4'b0001;
    repeat (4) tick();
    repeat (7) tick();
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL dx_hold: got %b want 0001", grant); end
    done = 1'b1;
    tick();
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL dx_end: got %b want 0000", grant); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL dx_no_tmo: got %b want 0", timeout); end
    repeat (2) tick();
    n_tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_done: got g=%b b=%b want g=0000 b=0", grant, busy); end
    n_tests++; if (timeout !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL idle_done2: got t=%b p=%b want t=0 p=0000", timeout, pending); end
    flush();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    repeat (4) tick();
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL rm_grant: got %b want 0100", grant); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_async: got g=%b b=%b want g=0000 b=0", grant, busy); end
    n_tests++; if (timeout !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL rm_async2: got t=%b p=%b want t=0 p=0000", timeout, pending); end
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    n_tests++; if (grant !== 4'b0000 || pending !== 4'b0000) begin n_fail++; $display("FAIL rm_held: got g=%b p=%b want g=0000 p=0000", grant, pending); end
    req = 4'b0000;
    repeat (4) tick();
    req = 4'b0100;
    repeat (4) tick();
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL rm_rearm: got %b want 0100", grant); end
    done = 1'b1;
    tick();
    flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_two_same();
    test_single();
    test_rr_wrap();
    test_timeout();
    test_rr_ptr2();
    test_overrun();
    test_rereq();
    test_done_expiry();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
